// File: rtl/uart_param_transceiver.sv
// Parametrised full-duplex UART with 16x oversampled RX and four run-time baud divisors.
// Define UART_LOOPBACK_EN to add the loopback input (RX fed from internal TX, TX pin held idle).
module uart_param_transceiver #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 1,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned DIV_0     = 1,
   parameter int unsigned DIV_1     = 2,
   parameter int unsigned DIV_2     = 4,
   parameter int unsigned DIV_3     = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [1:0]           baud_sel,
   input  logic                 TXstart,
   input  logic [DATA_BITS-1:0] TX_data_in,
   output logic                 TX_out,
   output logic                 TXbusy,
   input  logic                 RX_in,
`ifdef UART_LOOPBACK_EN
   input  logic                 loopback,
`endif
   output logic [DATA_BITS-1:0] RX_DATA_OUT,
   output logic                 RX_valid,
   output logic                 parity_error,
   output logic                 stop_bit_error,
   output logic [1:0]           BAUD_RATE
);

   localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   tx_state_t tx_state, tx_next;
   rx_state_t rx_state, rx_next;

   logic [15:0]          tx_pre, rx_pre;
   logic                 tx_tick, rx_tick;
   logic [3:0]           tx_ticks, rx_ticks;
   logic [3:0]           tx_bit, rx_bit;
   logic [DATA_BITS-1:0] tx_shreg, rx_shreg;
   logic                 tx_par, rx_par;
   logic                 tx_serial, tx_accept, tx_end;
   logic                 rx_src, rx_s, rx_prev, rx_fall, rx_start, rx_mid, rx_end, rx_done;
   logic [1:0]           rx_sync;
   logic                 rx_stop_acc;
   logic                 both_idle;
   logic [1:0]           rate_next;

   function automatic logic [15:0] div_load(input logic [1:0] sel);
      case (sel)
         2'd0:    div_load = 16'(DIV_0 - 1);
         2'd1:    div_load = 16'(DIV_1 - 1);
         2'd2:    div_load = 16'(DIV_2 - 1);
         default: div_load = 16'(DIV_3 - 1);
      endcase
   endfunction

`ifdef UART_LOOPBACK_EN
   assign TX_out = loopback ? 1'b1 : tx_serial;
   assign rx_src = loopback ? tx_serial : RX_in;
`else
   assign TX_out = tx_serial;
   assign rx_src = RX_in;
`endif

   // A frame starting this cycle already runs at the newly selected rate.
   assign both_idle = (tx_state == TX_IDLE) && (rx_state == RX_IDLE);
   assign rate_next = both_idle ? baud_sel : BAUD_RATE;
   assign tx_accept = (tx_state == TX_IDLE) && TXstart;
   assign rx_start  = (rx_state == RX_IDLE) && rx_fall;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) BAUD_RATE <= '0;
      else          BAUD_RATE <= rate_next;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_pre <= '0;
         rx_pre <= '0;
      end else begin
         if (tx_accept)        tx_pre <= div_load(rate_next);
         else if (tx_pre == 0) tx_pre <= div_load(BAUD_RATE);
         else                  tx_pre <= tx_pre - 16'd1;
         if (rx_start)         rx_pre <= div_load(rate_next);
         else if (rx_pre == 0) rx_pre <= div_load(BAUD_RATE);
         else                  rx_pre <= rx_pre - 16'd1;
      end
   end

   assign tx_tick = (tx_pre == 16'd0);
   assign rx_tick = (rx_pre == 16'd0);
   assign tx_end  = tx_tick && (tx_ticks == 4'd15);

   // ---------------- TX ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) tx_state <= TX_IDLE;
      else          tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         TX_IDLE:   if (TXstart) tx_next = TX_START;
         TX_START:  if (tx_end) tx_next = TX_DATA;
         TX_DATA:   if (tx_end && tx_bit == DLAST) tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
         TX_PARITY: if (tx_end) tx_next = TX_STOP;
         TX_STOP:   if (tx_end && tx_bit == SLAST) tx_next = TX_IDLE;
         default:   tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_serial = 1'b1;
      TXbusy    = 1'b1;
      unique case (tx_state)
         TX_IDLE:   TXbusy    = 1'b0;
         TX_START:  tx_serial = 1'b0;
         TX_DATA:   tx_serial = tx_shreg[0];
         TX_PARITY: tx_serial = tx_par;
         default:   tx_serial = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_shreg <= '0;
         tx_par   <= 1'b0;
         tx_ticks <= '0;
         tx_bit   <= '0;
      end else if (tx_accept) begin
         tx_shreg <= TX_data_in;
         tx_par   <= (PARITY == 2) ? ~^TX_data_in : ^TX_data_in;
         tx_ticks <= '0;
         tx_bit   <= '0;
      end else if (tx_tick && tx_state != TX_IDLE) begin
         tx_ticks <= tx_ticks + 4'd1;
         if (tx_end) begin
            tx_bit <= (tx_next != tx_state) ? 4'd0 : tx_bit + 4'd1;
            if (tx_state == TX_DATA) tx_shreg <= tx_shreg >> 1;
         end
      end
   end

   // ---------------- RX ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], rx_src};
         rx_prev <= rx_s;
      end
   end

   // A line held low (break) never shows a falling edge, so RX rearms only after it returns high.
   assign rx_s    = rx_sync[1];
   assign rx_fall = rx_prev && !rx_s;
   assign rx_mid  = rx_tick && (rx_ticks == 4'd7);
   assign rx_end  = rx_tick && (rx_ticks == 4'd15);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rx_state <= RX_IDLE;
      else          rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         RX_IDLE:   if (rx_fall) rx_next = RX_START;
         RX_START:  if (rx_mid && rx_s) rx_next = RX_IDLE;
                    else if (rx_end) rx_next = RX_DATA;
         RX_DATA:   if (rx_end && rx_bit == DLAST) rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_end) rx_next = RX_STOP;
         RX_STOP:   if (rx_mid && rx_bit == SLAST) rx_next = RX_IDLE;
         default:   rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_done = (rx_state == RX_STOP) && rx_mid && (rx_bit == SLAST);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_shreg       <= '0;
         rx_par         <= 1'b0;
         rx_ticks       <= '0;
         rx_bit         <= '0;
         rx_stop_acc    <= 1'b0;
         RX_DATA_OUT    <= '0;
         RX_valid       <= 1'b0;
         parity_error   <= 1'b0;
         stop_bit_error <= 1'b0;
      end else begin
         RX_valid <= rx_done;
         if (rx_start) begin
            rx_ticks    <= '0;
            rx_bit      <= '0;
            rx_stop_acc <= 1'b0;
         end else if (rx_tick && rx_state != RX_IDLE) begin
            rx_ticks <= rx_ticks + 4'd1;
            if (rx_mid) begin
               unique case (rx_state)
                  RX_DATA:   rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                  RX_PARITY: rx_par   <= rx_s;
                  RX_STOP:   rx_stop_acc <= rx_stop_acc | !rx_s;
                  default:   ;
               endcase
            end
            if (rx_end) rx_bit <= (rx_next != rx_state) ? 4'd0 : rx_bit + 4'd1;
         end
         if (rx_done) begin
            RX_DATA_OUT    <= rx_shreg;
            stop_bit_error <= rx_stop_acc | !rx_s;
            if (PARITY == 0) parity_error <= 1'b0;
            else             parity_error <= (^{rx_shreg, rx_par}) ^ (PARITY == 2);
         end
      end
   end

endmodule

// File: tb/tb_uart_param_transceiver.sv
// Bench for uart_param_transceiver (default parameters): frame-level reference model,
// random data/baud, TX bit timing, RX error flags, false start, break, baud hold and reset.
module tb_uart_param_transceiver;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [1:0] baud_sel;
   logic       TXstart;
   logic [7:0] TX_data_in;
   logic       TX_out, TXbusy;
   logic [7:0] RX_DATA_OUT;
   logic       RX_valid, parity_error, stop_bit_error;
   logic [1:0] BAUD_RATE;
   logic       rx_line, loop_mode, rx_pin;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [9:0]  rx_q[$];

   assign rx_pin = loop_mode ? TX_out : rx_line;

   uart_param_transceiver dut (
      .clock(clock), .reset_n(reset_n), .baud_sel(baud_sel),
      .TXstart(TXstart), .TX_data_in(TX_data_in), .TX_out(TX_out), .TXbusy(TXbusy),
      .RX_in(rx_pin),
`ifdef UART_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .RX_DATA_OUT(RX_DATA_OUT), .RX_valid(RX_valid),
      .parity_error(parity_error), .stop_bit_error(stop_bit_error), .BAUD_RATE(BAUD_RATE)
   );

   always #5 clock = ~clock;

   always @(negedge clock)
      if (RX_valid === 1'b1) rx_q.push_back({parity_error, stop_bit_error, RX_DATA_OUT});

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame as sent on the wire, bit 0 first: start, data LSB first, even parity, stop.
   function automatic logic [10:0] frame_of(input logic [7:0] d, input logic bad_par,
                                            input logic stop);
      return {stop, (^d) ^ bad_par, d, 1'b0};
   endfunction

   function automatic int unsigned div_of(input logic [1:0] s);
      return 32'd1 << s;
   endfunction

   task automatic set_baud(input logic [1:0] s);
      baud_sel = s;
      repeat (3) @(posedge clock);
      #1;
      check("baud_apply", 32'(BAUD_RATE), 32'(s));
   endtask

   // Caller raises TXstart before; the next edge accepts the frame.
   task automatic run_tx(input string tag, input logic [7:0] d, input int unsigned div,
                         input logic hold, input int change_at, input logic [1:0] new_sel,
                         input logic [1:0] old_sel);
      logic [10:0] f;
      logic        smp[$];
      logic        got;
      int          n, idx;
      f = frame_of(d, 1'b0, 1'b1);
      @(posedge clock);
      #1;
      if (!hold) TXstart = 1'b0;
      check({tag, "_busy_first"}, 32'(TXbusy), 32'd1);
      n = 0;
      while (TXbusy === 1'b1 && n < 20000) begin
         smp.push_back(TX_out);
         if (n == change_at) baud_sel = new_sel;
         if (change_at >= 0 && n == change_at + 2)
            check({tag, "_baud_hold"}, 32'(BAUD_RATE), 32'(old_sel));
         n++;
         @(posedge clock);
         #1;
      end
      check({tag, "_busy_len"}, 32'(n), 32'(16 * div * 11));
      for (int k = 0; k < 11; k++) begin
         idx = int'(16 * div) * k + int'(8 * div);
         got = (idx < smp.size()) ? smp[idx] : 1'bz;
         check({tag, "_bit"}, 32'(got), 32'(f[0]));
         f = f >> 1;
      end
   endtask

   task automatic rx_send(input logic [7:0] d, input logic bad_par, input logic stop,
                          input int unsigned div);
      logic [10:0] f;
      f = frame_of(d, bad_par, stop);
      for (int k = 0; k < 11; k++) begin
         rx_line = f[0];
         f = f >> 1;
         repeat (16 * div) @(posedge clock);
         #1;
      end
      rx_line = 1'b1;
      repeat (32 * div) @(posedge clock);
      #1;
   endtask

   task automatic expect_rx(input string tag, input logic [7:0] d, input logic pe,
                            input logic se);
      logic [9:0] r;
      check({tag, "_count"}, 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) begin
         r = rx_q.pop_front();
         check({tag, "_data"}, 32'(r[7:0]), 32'(d));
         check({tag, "_parity_err"}, 32'(r[9]), 32'(pe));
         check({tag, "_stop_err"}, 32'(r[8]), 32'(se));
      end
      rx_q.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic [1:0] s;
      logic       bp, bs;

      reset_n = 1'b0; baud_sel = 2'd2; TXstart = 1'b0; TX_data_in = '0;
      rx_line = 1'b1; loop_mode = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_tx_out", 32'(TX_out), 32'd1);
      check("rst_busy", 32'(TXbusy), 32'd0);
      check("rst_valid", 32'(RX_valid), 32'd0);
      check("rst_rx_data", 32'(RX_DATA_OUT), 32'd0);
      check("rst_perr", 32'(parity_error), 32'd0);
      check("rst_serr", 32'(stop_bit_error), 32'd0);
      check("rst_baud", 32'(BAUD_RATE), 32'd0);
      reset_n = 1'b1;

      set_baud(2'd1);
      loop_mode = 1'b1;
      TX_data_in = 8'hB3; TXstart = 1'b1;
      run_tx("lb_b3", 8'hB3, 2, 1'b0, -1, 2'd0, 2'd0);
      repeat (4) @(posedge clock);
      #1;
      expect_rx("lb_b3", 8'hB3, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         s = 2'($urandom_range(0, 3));
         set_baud(s);
         d = 8'($urandom);
         TX_data_in = d; TXstart = 1'b1;
         run_tx("lb_rand", d, div_of(s), 1'b0, -1, 2'd0, 2'd0);
         repeat (4) @(posedge clock);
         #1;
         expect_rx("lb_rand", d, 1'b0, 1'b0);
      end
      loop_mode = 1'b0;

      set_baud(2'd1);
      rx_send(8'hB3, 1'b1, 1'b1, 2);
      expect_rx("rx_par", 8'hB3, 1'b1, 1'b0);
      rx_send(8'h5A, 1'b0, 1'b0, 2);
      expect_rx("rx_stop", 8'h5A, 1'b0, 1'b1);
      rx_send(8'h0F, 1'b0, 1'b1, 2);
      expect_rx("rx_clean", 8'h0F, 1'b0, 1'b0);

      rx_line = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      rx_line = 1'b1;
      repeat (200) @(posedge clock);
      #1;
      check("false_start_count", 32'(rx_q.size()), 32'd0);
      rx_send(8'hC5, 1'b0, 1'b1, 2);
      expect_rx("after_false", 8'hC5, 1'b0, 1'b0);

      rx_line = 1'b0;
      repeat (16 * 2 * 12) @(posedge clock);
      #1;
      rx_line = 1'b1;
      repeat (64) @(posedge clock);
      #1;
      expect_rx("break", 8'h00, 1'b0, 1'b1);
      rx_send(8'h3C, 1'b0, 1'b1, 2);
      expect_rx("after_break", 8'h3C, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         s = 2'($urandom_range(0, 3));
         set_baud(s);
         d  = 8'($urandom);
         bp = ($urandom_range(0, 2) == 0);
         bs = ($urandom_range(0, 2) == 0);
         rx_send(d, bp, !bs, div_of(s));
         expect_rx("rx_rand", d, bp, bs);
      end

      set_baud(2'd1);
      TX_data_in = 8'h6D; TXstart = 1'b1;
      run_tx("baud_chg", 8'h6D, 2, 1'b0, 100, 2'd3, 2'd1);
      @(posedge clock);
      #1;
      check("baud_after_idle", 32'(BAUD_RATE), 32'd3);
      TX_data_in = 8'h92; TXstart = 1'b1;
      run_tx("slow", 8'h92, 8, 1'b0, -1, 2'd0, 2'd0);

      set_baud(2'd1);
      TX_data_in = 8'hE7; TXstart = 1'b1;
      @(posedge clock);
      #1;
      TXstart = 1'b0;
      repeat (100) @(posedge clock);
      #1;
      check("rst_pre_busy", 32'(TXbusy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_tx_out", 32'(TX_out), 32'd1);
      check("rst_mid_busy", 32'(TXbusy), 32'd0);
      baud_sel = 2'd0; TX_data_in = 8'h1E; TXstart = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      run_tx("post_rst", 8'h1E, 1, 1'b1, -1, 2'd0, 2'd0);
      check("b2b_gap", 32'(TXbusy), 32'd0);
      TX_data_in = 8'hA5;
      run_tx("b2b", 8'hA5, 1, 1'b0, -1, 2'd0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
